// File: rtl/codeword_deserializer.sv
// Serial-to-parallel codeword assembler that launches an external decoder and
// collects its result, with completion-on-rising-edge, timeout and overrun reporting.
module codeword_deserializer #(
  parameter int N       = 64,
  parameter int K       = 40,
  parameter int TIMEOUT = 1023
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         ser_in,
  input  logic         ser_valid,
  output logic         ser_ready,
  output logic [N-1:0] codeword,
  output logic         dec_start,
  input  logic         dec_done,
  input  logic [K-1:0] dec_data,
  output logic [K-1:0] data_out,
  output logic         data_valid,
  output logic         timeout,
  output logic         overrun,
  output logic [7:0]   frame_cnt
);

  localparam int BW = (N > 1) ? $clog2(N) : 1;
  localparam int WW = $clog2(TIMEOUT + 1) + 1;

  localparam logic [BW-1:0] BIT_LAST = BW'(N - 1);
  localparam logic [BW-1:0] BIT_ONE  = BW'(1);
  localparam logic [WW-1:0] WAIT_MAX = WW'(TIMEOUT);
  localparam logic [WW-1:0] WAIT_ONE = WW'(1);

  typedef enum logic [1:0] {
    ST_SHIFT  = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2
  } state_e;

  state_e        state_q;
  logic [BW-1:0] bit_cnt_q;
  logic [WW-1:0] wait_cnt_q;
  logic [N-1:0]  codeword_q;
  logic [K-1:0]  data_out_q;
  logic [7:0]    frame_cnt_q;
  logic          ser_ready_q;
  logic          dec_start_q;
  logic          data_valid_q;
  logic          timeout_q;
  logic          done_prev_q;
  logic          dec_rise;

  // Only a fresh low-to-high transition of dec_done counts as completion.
  assign dec_rise = dec_done & ~done_prev_q;

  // Frame FSM with registered handshake and status outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_SHIFT;
      bit_cnt_q    <= '0;
      wait_cnt_q   <= '0;
      codeword_q   <= '0;
      data_out_q   <= '0;
      frame_cnt_q  <= 8'd0;
      ser_ready_q  <= 1'b1;
      dec_start_q  <= 1'b0;
      data_valid_q <= 1'b0;
      timeout_q    <= 1'b0;
      done_prev_q  <= 1'b0;
    end else begin
      done_prev_q  <= dec_done;
      dec_start_q  <= 1'b0;
      data_valid_q <= 1'b0;
      timeout_q    <= 1'b0;
      case (state_q)
        ST_SHIFT: begin
          if (ser_valid) begin
            codeword_q <= {codeword_q[N-2:0], ser_in};
            if (bit_cnt_q == BIT_LAST) begin
              bit_cnt_q   <= '0;
              state_q     <= ST_LAUNCH;
              dec_start_q <= 1'b1;
              ser_ready_q <= 1'b0;
            end else begin
              bit_cnt_q <= bit_cnt_q + BIT_ONE;
            end
          end
        end
        ST_LAUNCH: begin
          state_q    <= ST_WAIT;
          wait_cnt_q <= '0;
        end
        ST_WAIT: begin
          // Completion is checked first so it wins over a coincident timeout.
          if (dec_rise) begin
            data_out_q   <= dec_data;
            data_valid_q <= 1'b1;
            frame_cnt_q  <= frame_cnt_q + 8'd1;
            state_q      <= ST_SHIFT;
            ser_ready_q  <= 1'b1;
          end else if (wait_cnt_q == WAIT_MAX) begin
            timeout_q   <= 1'b1;
            state_q     <= ST_SHIFT;
            ser_ready_q <= 1'b1;
          end else begin
            wait_cnt_q <= wait_cnt_q + WAIT_ONE;
          end
        end
        default: begin
          state_q     <= ST_SHIFT;
          bit_cnt_q   <= '0;
          ser_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign ser_ready  = ser_ready_q;
  assign codeword   = codeword_q;
  assign dec_start  = dec_start_q;
  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign timeout    = timeout_q;
  assign frame_cnt  = frame_cnt_q;
  // A bit offered while not ready is dropped and flagged in the same cycle.
  assign overrun    = ser_valid & ~ser_ready_q;

endmodule

// File: tb/tb_codeword_deserializer.sv
// Directed, table-driven bench for codeword_deserializer with hand-written
// sequences for held done, overrun, timeout, mid-frame reset and counter wrap.
module tb_codeword_deserializer;

  localparam int N  = 64;
  localparam int K  = 40;
  localparam int TO = 15;

  logic         clk = 1'b0;
  logic         reset;
  logic         ser_in;
  logic         ser_valid;
  logic         ser_ready;
  logic [N-1:0] codeword;
  logic         dec_start;
  logic         dec_done;
  logic [K-1:0] dec_data;
  logic [K-1:0] data_out;
  logic         data_valid;
  logic         timeout;
  logic         overrun;
  logic [7:0]   frame_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  codeword_deserializer #(.N(N), .K(K), .TIMEOUT(TO)) dut (
    .clk        (clk),
    .reset      (reset),
    .ser_in     (ser_in),
    .ser_valid  (ser_valid),
    .ser_ready  (ser_ready),
    .codeword   (codeword),
    .dec_start  (dec_start),
    .dec_done   (dec_done),
    .dec_data   (dec_data),
    .data_out   (data_out),
    .data_valid (data_valid),
    .timeout    (timeout),
    .overrun    (overrun),
    .frame_cnt  (frame_cnt)
  );

  typedef struct {
    logic [N-1:0] word;
    bit           gap;
    int           dly;
    logic [K-1:0] dec;
    logic [K-1:0] exp_data;
    logic [7:0]   exp_cnt;
    int           exp_cycles;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [N-1:0] w, input bit gap, input bit hold_valid,
                            output int cycles);
    cycles = 0;
    check("ready_at_start", 64'(ser_ready), 64'd1);
    for (int i = N - 1; i >= 0; i--) begin
      if (gap && i != N - 1) begin
        ser_valid = 1'b0;
        tick();
        cycles++;
      end
      ser_valid = 1'b1;
      ser_in    = w[i];
      tick();
      cycles++;
    end
    ser_valid = hold_valid;
    ser_in    = 1'b1;
    check("dec_start_pulse", 64'(dec_start), 64'd1);
    check("codeword_assembled", 64'(codeword), 64'(w));
    check("ready_low_launch", 64'(ser_ready), 64'd0);
    if (hold_valid) check("overrun_launch", 64'(overrun), 64'd1);
  endtask

  task automatic finish_decode(input logic [N-1:0] w, input int dly, input logic [K-1:0] data,
                               input logic [K-1:0] exp_data, input logic [7:0] exp_cnt,
                               input bit hold_valid, input bit keep_done);
    int starts = 0;
    int early  = 0;
    for (int d = 0; d < dly; d++) begin
      tick();
      if (dec_start) starts++;
      if (data_valid || timeout) early++;
      if (hold_valid) check("overrun_wait", 64'(overrun), 64'd1);
    end
    dec_done = 1'b1;
    dec_data = data;
    tick();
    check("single_dec_start", 64'(starts), 64'd0);
    check("no_early_result", 64'(early), 64'd0);
    check("data_valid_pulse", 64'(data_valid), 64'd1);
    check("data_out", 64'(data_out), 64'(exp_data));
    check("frame_cnt", 64'(frame_cnt), 64'(exp_cnt));
    check("no_timeout_on_done", 64'(timeout), 64'd0);
    check("codeword_stable", 64'(codeword), 64'(w));
    check("ready_after_done", 64'(ser_ready), 64'd1);
    ser_valid = 1'b0;
    if (!keep_done) dec_done = 1'b0;
    tick();
    check("data_valid_once", 64'(data_valid), 64'd0);
    check("timeout_quiet", 64'(timeout), 64'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no_finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int           cyc;
    int           early;
    logic [N-1:0] w;
    logic [K-1:0] d;

    vecs[0] = '{64'hD900_0000_0000_0001, 1'b0, 10, 40'h9D5486AA91, 40'h9D5486AA91, 8'd1, 64};
    vecs[1] = '{64'hD900_0000_0000_0001, 1'b1, 10, 40'h9D5486AA91, 40'h9D5486AA91, 8'd2, 127};
    vecs[2] = '{64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1,  40'hFF_FFFF_FFFF, 40'hFF_FFFF_FFFF, 8'd3, 64};
    vecs[3] = '{64'hA5A5_0F0F_3C3C_8001, 1'b0, 16, 40'h12_3456_789A, 40'h12_3456_789A, 8'd4, 64};
    vecs[4] = '{64'h0000_0000_0000_0000, 1'b0, 15, 40'h00_0000_0001, 40'h00_0000_0001, 8'd5, 64};

    // Reset state, with ser_valid asserted to show no overrun during reset.
    reset     = 1'b0;
    ser_in    = 1'b1;
    ser_valid = 1'b1;
    dec_done  = 1'b0;
    dec_data  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_codeword", 64'(codeword), 64'd0);
    check("rst_data_out", 64'(data_out), 64'd0);
    check("rst_frame_cnt", 64'(frame_cnt), 64'd0);
    check("rst_dec_start", 64'(dec_start), 64'd0);
    check("rst_data_valid", 64'(data_valid), 64'd0);
    check("rst_timeout", 64'(timeout), 64'd0);
    check("rst_overrun", 64'(overrun), 64'd0);
    ser_valid = 1'b0;
    reset     = 1'b1;
    tick();
    check("ready_after_reset", 64'(ser_ready), 64'd1);

    // Table: plain, gapped, all-ones, completion coinciding with timeout, all-zeros.
    foreach (vecs[i]) begin
      send_frame(vecs[i].word, vecs[i].gap, 1'b0, cyc);
      check("assembly_cycles", 64'(cyc), 64'(vecs[i].exp_cycles));
      finish_decode(vecs[i].word, vecs[i].dly, vecs[i].dec, vecs[i].exp_data,
                    vecs[i].exp_cnt, 1'b0, 1'b0);
    end

    // dec_done left high: only a fresh rising edge completes the next frame.
    send_frame(64'h0123_4567_89AB_CDEF, 1'b0, 1'b0, cyc);
    finish_decode(64'h0123_4567_89AB_CDEF, 4, 40'h11_2233_4455, 40'h11_2233_4455, 8'd6, 1'b0, 1'b1);
    send_frame(64'hFEDC_BA98_7654_3210, 1'b0, 1'b0, cyc);
    early = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (data_valid) early++;
    end
    check("held_done_ignored", 64'(early), 64'd0);
    check("held_done_cnt", 64'(frame_cnt), 64'd6);
    dec_done = 1'b0;
    tick();
    dec_done = 1'b1;
    dec_data = 40'h66_7788_99AA;
    tick();
    check("fresh_rise_valid", 64'(data_valid), 64'd1);
    check("fresh_rise_data", 64'(data_out), 64'h66_7788_99AA);
    check("fresh_rise_cnt", 64'(frame_cnt), 64'd7);
    dec_done = 1'b0;
    tick();
    check("fresh_rise_once", 64'(data_valid), 64'd0);

    // ser_valid held through LAUNCH/WAIT, then a clean frame.
    send_frame(64'h5555_AAAA_3333_CCCC, 1'b0, 1'b1, cyc);
    finish_decode(64'h5555_AAAA_3333_CCCC, 5, 40'hAB_CDEF_0123, 40'hAB_CDEF_0123, 8'd8, 1'b1, 1'b0);
    check("overrun_clear", 64'(overrun), 64'd0);
    send_frame(64'h8000_0000_0000_0003, 1'b0, 1'b0, cyc);
    finish_decode(64'h8000_0000_0000_0003, 3, 40'h0F_0F0F_0F0F, 40'h0F_0F0F_0F0F, 8'd9, 1'b0, 1'b0);

    // Decoder never finishes: timeout after TIMEOUT+1 WAIT cycles.
    send_frame(64'h1111_2222_3333_4444, 1'b0, 1'b0, cyc);
    early = 0;
    for (int k = 0; k < 16; k++) begin
      tick();
      if (timeout || data_valid) early++;
    end
    check("no_early_timeout", 64'(early), 64'd0);
    check("ready_low_wait", 64'(ser_ready), 64'd0);
    tick();
    check("timeout_pulse", 64'(timeout), 64'd1);
    check("timeout_ready", 64'(ser_ready), 64'd1);
    check("timeout_data_kept", 64'(data_out), 64'h0F_0F0F_0F0F);
    check("timeout_cnt_kept", 64'(frame_cnt), 64'd9);
    check("timeout_no_valid", 64'(data_valid), 64'd0);
    tick();
    check("timeout_once", 64'(timeout), 64'd0);

    // Reset after 30 bits, then 256 frames to wrap the frame counter.
    w = 64'hFFFF_FFFF_FFFF_FFFF;
    for (int i = 0; i < 30; i++) begin
      ser_valid = 1'b1;
      ser_in    = w[i];
      tick();
    end
    ser_valid = 1'b0;
    #1 reset = 1'b0;
    #1;
    check("midrst_codeword", 64'(codeword), 64'd0);
    check("midrst_cnt", 64'(frame_cnt), 64'd0);
    check("midrst_data_out", 64'(data_out), 64'd0);
    #1 reset = 1'b1;
    tick();
    send_frame(64'hD900_0000_0000_0001, 1'b0, 1'b0, cyc);
    finish_decode(64'hD900_0000_0000_0001, 10, 40'h9D5486AA91, 40'h9D5486AA91, 8'd1, 1'b0, 1'b0);
    for (int f = 2; f <= 256; f++) begin
      w = {32'hC0DE_0000 + 32'(f), ~32'(f)};
      d = 40'(f) * 40'd3;
      send_frame(w, 1'b0, 1'b0, cyc);
      finish_decode(w, 1, d, d, 8'(f), 1'b0, 1'b0);
    end
    check("frame_cnt_wrap", 64'(frame_cnt), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/codeword_deserializer.md
CODEWORD_DESERIALIZER -- requirements
Module: codeword_deserializer

Interface
REQ-001 The block SHALL have parameter N, default 64, meaning codeword width in bits.
REQ-002 The block SHALL have parameter K, default 40, meaning decoded message width in bits.
REQ-003 The block SHALL have parameter TIMEOUT, default 1023, meaning the maximum number of WAIT cycles before abandoning a frame.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port ser_in, input, 1 bit: serial codeword bit, MSB first.
REQ-007 The block SHALL have port ser_valid, input, 1 bit: ser_in is valid this cycle.
REQ-008 The block SHALL have port ser_ready, output, 1 bit: block accepts serial bits this cycle.
REQ-009 The block SHALL have port codeword, output, N bits: assembled codeword, wired to decoder data_in.
REQ-010 The block SHALL have port dec_start, output, 1 bit: decoder start pulse.
REQ-011 The block SHALL have port dec_done, input, 1 bit: decoder done level.
REQ-012 The block SHALL have port dec_data, input, K bits: decoder data_out.
REQ-013 The block SHALL have port data_out, output, K bits: last successfully decoded message.
REQ-014 The block SHALL have port data_valid, output, 1 bit: one-cycle pulse, data_out just updated.
REQ-015 The block SHALL have port timeout, output, 1 bit: one-cycle pulse, frame abandoned.
REQ-016 The block SHALL have port overrun, output, 1 bit: one-cycle pulse, ser_valid seen while ser_ready low.
REQ-017 The block SHALL have port frame_cnt, output, 8 bits: count of successful frames, wraps 255->0.

Function
REQ-018 The FSM SHALL have three states: SHIFT, LAUNCH, WAIT.
REQ-019 In SHIFT, ser_ready SHALL be 1; each cycle with ser_valid=1 SHALL perform codeword <= {codeword[N-2:0], ser_in} and increment a bit counter (0..N-1).
REQ-020 In SHIFT, cycles with ser_valid=0 SHALL leave codeword and the bit counter unchanged (gaps allowed).
REQ-021 The accepted bit with counter == N-1 SHALL clear the counter and move the FSM to LAUNCH on the same edge.
REQ-022 In LAUNCH, dec_start SHALL be 1 for exactly one cycle, and the FSM SHALL then move unconditionally to WAIT.
REQ-023 codeword SHALL remain stable from entry into LAUNCH until the FSM returns to SHIFT.
REQ-024 In LAUNCH and WAIT, ser_ready SHALL be 0.
REQ-025 A cycle in which ser_valid=1 and ser_ready=0 SHALL drop the bit and assert overrun for that cycle.
REQ-026 Completion SHALL be defined as a rising edge of dec_done (high this cycle, low the previous cycle) detected while in WAIT; a level still high from the previous frame SHALL NOT count.
REQ-027 On completion, the block SHALL perform data_out <= dec_data, assert data_valid for one cycle, increment frame_cnt modulo 256, and return to SHIFT.
REQ-028 The WAIT cycle counter SHALL clear on entry to WAIT; if it reaches TIMEOUT without completion, the block SHALL assert timeout for one cycle and return to SHIFT, with data_out and frame_cnt unchanged.
REQ-029 If completion and timeout coincide in the same cycle, completion SHALL win and timeout SHALL stay 0.
REQ-030 Latency SHALL be: the last serial bit at edge t gives dec_start high during cycle t+1; a dec_done rise sampled at edge u gives data_valid and the new data_out during cycle u+1.

Reset
REQ-031 When reset=0, asynchronously: state=SHIFT, bit counter=0, WAIT counter=0, codeword=0, data_out=0, frame_cnt=0; dec_start, data_valid, timeout and overrun SHALL be 0; the dec_done history register SHALL be 0.
REQ-032 ser_ready SHALL be 1 from the first clock edge after reset deasserts.
REQ-033 Reset asserted mid-frame or in WAIT SHALL discard the partial frame; the next frame SHALL start at bit 0.

Verification
REQ-034 Scenario: shift 64'hD900_0000_0000_0001 MSB first with no gaps; decoder model raises done 10 cycles after start with dec_data=40'h9D5486AA91 -> exactly one dec_start, codeword matches the input word, data_out=40'h9D5486AA91, one data_valid pulse, frame_cnt=1.
REQ-035 Scenario: the same frame with ser_valid low on every other cycle -> identical codeword and result; frame takes 127 cycles to assemble.
REQ-036 Scenario: ser_valid held high during LAUNCH/WAIT -> overrun pulses each such cycle; the next frame starts cleanly at bit 0.
REQ-037 Scenario: dec_done never rises, TIMEOUT=15 -> timeout pulses 16 cycles after WAIT entry; data_out and frame_cnt unchanged; ser_ready returns to 1.
REQ-038 Scenario: dec_done left high from the previous frame -> not treated as completion; the frame completes only on a fresh rising edge.
REQ-039 Scenario: reset pulsed after 30 bits, then a full frame sent, and 256 frames run in total -> the first frame decodes correctly and frame_cnt wraps to 0 after 256 frames.
